// File: rtl/mem_port_arb_pkg.sv
// Shared constants for the memory-port arbiter: FSM state encoding and channel indices.
package mem_port_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int CH_IFETCH = 0;
    localparam int CH_DATA   = 1;

endpackage

// File: rtl/mem_port_arb_pick.sv
// arb_pick: combinational winner selection. Fixed priority (highest index wins) or
// round-robin search starting at ptr, chosen by the RR_EN parameter.
module arb_pick #(
    parameter int NCH   = 2,
    parameter bit RR_EN = 1'b0
) (
    input  logic [NCH-1:0]         valid,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [$clog2(NCH)-1:0] winner,
    output logic                   found
);

    localparam int IW = $clog2(NCH);

    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (RR_EN) begin
            // Walk the ring backwards so the last hit is the one closest to ptr.
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (valid[idx]) begin
                    winner = IW'(idx);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (valid[i]) begin
                    winner = IW'(i);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: single-port memory arbiter, IDLE/BUSY handshake per access.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [NCH*WIDTH-1:0]   ch_addr,
    input  logic [NCH-1:0]         ch_we,
    output logic [NCH-1:0]         ch_ack,
    output logic [NCH-1:0]         ch_done,
    output logic                   mem_valid,
    output logic [WIDTH-1:0]       mem_addr,
    output logic                   mem_we,
    input  logic                   mem_ready,
    output logic [$clog2(NCH)-1:0] grant
);

    localparam int IW = $clog2(NCH);

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          found;
    logic          capture;

    assign capture = (state == ST_IDLE) && found;

`ifdef MEM_PORT_ARB_RR_EN
    localparam bit RR_EN = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (capture) begin
            ptr <= (winner == IW'(NCH - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    localparam bit RR_EN = 1'b0;

    assign ptr = '0;
`endif

    arb_pick #(
        .NCH   (NCH),
        .RR_EN (RR_EN)
    ) u_pick (
        .valid  (ch_valid),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            grant     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state     <= ST_BUSY;
                        mem_valid <= 1'b1;
                        mem_addr  <= ch_addr[int'(winner)*WIDTH +: WIDTH];
                        mem_we    <= ch_we[winner];
                        grant     <= winner;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        state     <= ST_IDLE;
                        mem_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ack is gated by rst_n so it stays low while reset is held, even with requests pending.
    always_comb begin
        ch_ack  = '0;
        ch_done = '0;
        if (rst_n && capture) begin
            ch_ack[winner] = 1'b1;
        end
        if (state == ST_BUSY && mem_ready) begin
            ch_done[grant] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus random traffic against a
// transaction-level reference model. Follows MEM_PORT_ARB_RR_EN for the arbitration rule.
module tb_mem_port_arb;
    import mem_port_arb_pkg::*;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int IW    = $clog2(NCH);

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       ch_valid;
    logic [NCH*WIDTH-1:0] ch_addr;
    logic [NCH-1:0]       ch_we;
    logic [NCH-1:0]       ch_ack;
    logic [NCH-1:0]       ch_done;
    logic                 mem_valid;
    logic [WIDTH-1:0]     mem_addr;
    logic                 mem_we;
    logic                 mem_ready;
    logic [IW-1:0]        grant;

    mem_port_arb #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_valid  (ch_valid),
        .ch_addr   (ch_addr),
        .ch_we     (ch_we),
        .ch_ack    (ch_ack),
        .ch_done   (ch_done),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one outstanding access at a time.
    bit               m_busy;
    int               m_grant;
    logic [WIDTH-1:0] m_addr;
    bit               m_we;
    int               m_ptr;

    // Snapshot of DUT outputs taken mid-cycle by run_cycle.
    logic [NCH-1:0]   obs_ack;
    logic [NCH-1:0]   obs_done;
    logic             obs_valid;
    logic [WIDTH-1:0] obs_addr;
    logic             obs_we;
    logic [IW-1:0]    obs_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NCH-1:0] v, input int start);
`ifdef MEM_PORT_ARB_RR_EN
        for (int k = 0; k < NCH; k++) begin
            if (v[(start + k) % NCH]) return (start + k) % NCH;
        end
`else
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [NCH*WIDTH-1:0] rand_addrs();
        logic [NCH*WIDTH-1:0] a;
        for (int i = 0; i < NCH; i++) a[i*WIDTH +: WIDTH] = $urandom;
        return a;
    endfunction

    // Called just after a rising edge: drive inputs, check mid-cycle, advance the model.
    task automatic run_cycle(input logic [NCH-1:0] v, input logic [NCH*WIDTH-1:0] a,
                             input logic [NCH-1:0] w, input logic r);
        int             sel;
        logic [NCH-1:0] exp_ack;
        logic [NCH-1:0] exp_done;
        ch_valid  = v;
        ch_addr   = a;
        ch_we     = w;
        mem_ready = r;
        @(negedge clk);
        sel      = pick(v, m_ptr);
        exp_ack  = '0;
        exp_done = '0;
        if (!m_busy && sel >= 0) exp_ack[sel] = 1'b1;
        if (m_busy && r) exp_done[m_grant] = 1'b1;
        obs_ack   = ch_ack;
        obs_done  = ch_done;
        obs_valid = mem_valid;
        obs_addr  = mem_addr;
        obs_we    = mem_we;
        obs_grant = grant;
        check("ch_ack", 64'(ch_ack), 64'(exp_ack));
        check("ch_done", 64'(ch_done), 64'(exp_done));
        check("mem_valid", 64'(mem_valid), 64'(m_busy));
        if (m_busy) begin
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mem_we", 64'(mem_we), 64'(m_we));
            check("grant", 64'(grant), 64'(m_grant));
        end
        @(posedge clk);
        if (!m_busy && sel >= 0) begin
            m_busy  = 1'b1;
            m_grant = sel;
            m_addr  = a[sel*WIDTH +: WIDTH];
            m_we    = w[sel];
            m_ptr   = (sel + 1) % NCH;
        end else if (m_busy && r) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ch_valid  = '1;
        mem_ready = 1'b1;
        #1;
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ch_ack", 64'(ch_ack), 64'd0);
        check("rst_ch_done", 64'(ch_done), 64'd0);
        m_busy  = 1'b0;
        m_grant = 0;
        m_ptr   = 0;
        ch_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NCH*WIDTH-1:0] a;
        logic [WIDTH-1:0]     held_addr;
        int                   seq[$];
        int                   exp_seq[5];
        logic [31:0]          rv;

        ch_valid  = '0;
        ch_addr   = '0;
        ch_we     = '0;
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        m_addr    = '0;
        m_we      = 1'b0;
        #2;
        do_reset();

        // Single fetch with memory always ready.
        a = '0;
        a[CH_IFETCH*WIDTH +: WIDTH] = 32'h0040_0000;
        run_cycle(4'b0001, a, 4'b0000, 1'b1);
        check("fetch_ack", 64'(obs_ack), 64'h1);
        run_cycle(4'b0000, a, 4'b0000, 1'b1);
        check("fetch_valid", 64'(obs_valid), 64'h1);
        check("fetch_addr", 64'(obs_addr), 64'h0040_0000);
        check("fetch_done", 64'(obs_done), 64'h1);
        run_cycle(4'b0000, a, 4'b0000, 1'b1);

        // Fetch/data collision; data drops its request after ack.
        a[CH_DATA*WIDTH +: WIDTH]   = 32'h1001_0004;
        a[CH_IFETCH*WIDTH +: WIDTH] = 32'h0040_0010;
        run_cycle(4'b0011, a, 4'b0010, 1'b0);
        run_cycle(4'b0001, a, 4'b0010, 1'b1);
`ifndef MEM_PORT_ARB_RR_EN
        check("coll_grant", 64'(obs_grant), 64'(CH_DATA));
        check("coll_addr", 64'(obs_addr), 64'h1001_0004);
        check("coll_we", 64'(obs_we), 64'h1);
        check("coll_done", 64'(obs_done), 64'h2);
`endif
        run_cycle(4'b0001, a, 4'b0010, 1'b1);
        check("coll_next_ack", 64'(obs_ack), 64'h1);
        run_cycle(4'b0000, a, 4'b0000, 1'b1);
        check("coll_next_grant", 64'(obs_grant), 64'(CH_IFETCH));
        run_cycle(4'b0000, a, 4'b0000, 1'b0);

        // Stall: address inputs churn while memory is not ready.
        a = rand_addrs();
        held_addr = a[2*WIDTH +: WIDTH];
        run_cycle(4'b0100, a, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rv = $urandom;
            run_cycle(rv[NCH-1:0], rand_addrs(), rv[2*NCH-1:NCH], 1'b0);
            check("stall_addr", 64'(obs_addr), 64'(held_addr));
            check("stall_grant", 64'(obs_grant), 64'd2);
            check("stall_done", 64'(obs_done), 64'd0);
        end
        run_cycle(4'b0000, a, 4'b0000, 1'b1);
        check("stall_release_done", 64'(obs_done), 64'h4);

        // Reset in the middle of an access.
        run_cycle(4'b0000, a, 4'b0000, 1'b0);
        run_cycle(4'b1000, a, 4'b1000, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(4'b0000, a, 4'b0000, 1'b1);
            check("post_rst_done", 64'(obs_done), 64'd0);
        end
        run_cycle(4'b0010, a, 4'b0000, 1'b1);
        check("post_rst_ack", 64'(obs_ack), 64'h2);
        run_cycle(4'b0000, a, 4'b0000, 1'b1);
        check("post_rst_addr", 64'(obs_addr), 64'(a[WIDTH +: WIDTH]));

        // All channels requesting continuously from a fresh reset.
        do_reset();
`ifdef MEM_PORT_ARB_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{3, 3, 3, 3, 3};
`endif
        for (int i = 0; i < 10; i++) begin
            run_cycle(4'b1111, a, 4'b0000, 1'b1);
            if (obs_valid) seq.push_back(int'(obs_grant));
        end
        check("seq_len", 64'(seq.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) check("seq_grant", 64'(seq[i]), 64'(exp_seq[i]));
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rv = $urandom;
            run_cycle(rv[NCH-1:0], rand_addrs(), rv[2*NCH-1:NCH], rv[8] | rv[9]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
